// File: rtl/spi_peripheral_if.sv
// Parallel word-stream side of spi_peripheral.
// The peripheral drives received words and the underrun flag.
// The host side feeds words to transmit through a valid/ready handshake.
interface spi_peripheral_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_underrun;

  // Peripheral view: emits received words, accepts words to transmit.
  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    output tx_underrun,
    input  tx_data,
    input  tx_valid
  );

  // Host view: the logic that feeds and drains the peripheral.
  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    input  tx_underrun,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI target with all pins oversampled in the system clock domain.
// A one-entry holding register feeds the tx shift register at each word
// start. Received words are presented with a one-cycle valid pulse.
module spi_peripheral #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = {DATA_WIDTH{1'b1}}
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sclk,
  input  logic            pico,
  input  logic            cs,
  output logic            poci,
  output logic            poci_oe,
  output logic            busy,
  spi_peripheral_if.slave bus
);

  localparam int               CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchronizer chains; *_prev_r is the edge-detect stage.
  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic pico_meta_r, pico_sync_r;
  logic cs_meta_r, cs_sync_r, cs_prev_r;

  // Arming: cs must be observed high from the pin after reset.
  logic [1:0] settle_r;
  logic       armed_r;

  logic [0:0] state_r;
  logic [0:0] state_nxt_s;
  logic       poci_oe_r;
  logic       busy_r;

  logic [CNT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_done_r;
  logic                  rx_valid_r;

  logic [DATA_WIDTH-1:0] tx_shift_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  tx_ready_r;
  logic                  tx_underrun_r;

  logic sclk_lead_s, sclk_trail_s;
  logic cs_fall_s, cs_rise_s;
  logic edge_ok_s, sample_s, shift_s;
  logic word_start_s, xfer_s;

  // Bring the asynchronous SPI pins into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_meta_r <= CPOL;
      sclk_sync_r <= CPOL;
      sclk_prev_r <= CPOL;
      pico_meta_r <= 1'b1;
      pico_sync_r <= 1'b1;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      pico_meta_r <= pico;
      pico_sync_r <= pico_meta_r;
      cs_meta_r   <= cs;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
    end
  end

  // Arm only after a real pin sample of cs high, so a frame already in
  // progress when reset releases is never picked up halfway.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end
      if (settle_r[1] && cs_sync_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Edge and event decode from the synchronized pin values.
  always_comb begin
    sclk_lead_s  = (sclk_prev_r == CPOL) && (sclk_sync_r != CPOL);
    sclk_trail_s = (sclk_prev_r != CPOL) && (sclk_sync_r == CPOL);
    cs_fall_s    = (state_r == ST_IDLE) && armed_r && cs_prev_r && !cs_sync_r;
    cs_rise_s    = (state_r == ST_ACTIVE) && !cs_prev_r && cs_sync_r;
    edge_ok_s    = (state_r == ST_ACTIVE) && !cs_rise_s;
    sample_s     = edge_ok_s && (CPHA ? sclk_trail_s : sclk_lead_s);
    shift_s      = edge_ok_s && (CPHA ? sclk_lead_s : sclk_trail_s);
    // A shift edge with the counter at zero opens a new word; for CPHA=0
    // the first word opens on the cs fall itself.
    word_start_s = (shift_s && (bit_cnt_r == CNT_ZERO)) || (!CPHA && cs_fall_s);
    xfer_s       = bus.tx_valid && tx_ready_r;
  end

  // Frame state: IDLE until an armed cs fall, ACTIVE until cs rises.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Register the state with its pad enable and busy flag so they track exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      poci_oe_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      poci_oe_r <= (state_nxt_s == ST_ACTIVE);
      busy_r    <= (state_nxt_s == ST_ACTIVE);
    end
  end

  // Receive path: shift in on sample edges, publish on the last bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_r  <= CNT_ZERO;
      rx_shift_r <= {DATA_WIDTH{1'b0}};
      rx_data_r  <= {DATA_WIDTH{1'b0}};
      rx_done_r  <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_done_r;
      rx_done_r  <= 1'b0;
      if (cs_rise_s || cs_fall_s) begin
        // A cs edge always restarts the word; a partial word is dropped.
        bit_cnt_r <= CNT_ZERO;
      end else if (sample_s) begin
        rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], pico_sync_r};
        if (bit_cnt_r == LAST_BIT) begin
          rx_data_r <= {rx_shift_r[DATA_WIDTH-2:0], pico_sync_r};
          rx_done_r <= 1'b1;
          bit_cnt_r <= CNT_ZERO;
        end else begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Transmit path: holding register handshake, word-start load and shifting.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift_r    <= {DATA_WIDTH{1'b1}};
      hold_r        <= {DATA_WIDTH{1'b0}};
      tx_ready_r    <= 1'b1;
      tx_underrun_r <= 1'b0;
    end else begin
      tx_underrun_r <= 1'b0;
      if (word_start_s) begin
        if (!tx_ready_r) begin
          tx_shift_r <= hold_r;
          tx_ready_r <= 1'b1;
        end else begin
          // Empty at word start: a word handed over in this same cycle
          // waits for the next word start.
          tx_shift_r    <= IDLE_WORD;
          tx_underrun_r <= 1'b1;
          if (xfer_s) begin
            hold_r     <= bus.tx_data;
            tx_ready_r <= 1'b0;
          end
        end
      end else begin
        if (shift_s) begin
          tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b1};
        end
        if (xfer_s) begin
          hold_r     <= bus.tx_data;
          tx_ready_r <= 1'b0;
        end
      end
    end
  end

  assign poci            = tx_shift_r[DATA_WIDTH-1];
  assign poci_oe         = poci_oe_r;
  assign busy            = busy_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_ready    = tx_ready_r;
  assign bus.tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: one instance per CPOL/CPHA mode,
// each driven by a simple SPI controller model at clock/8.
module tb_spi_peripheral;

  localparam int H = 4;  // sclk half period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       sclk_v [4];
  logic       cs_v [4];
  logic       pico_v [4];
  logic       poci_v [4];
  logic       poci_oe_v [4];
  logic       busy_v [4];
  logic [7:0] tx_data_v [4];
  logic       tx_valid_v [4];
  logic [7:0] rx_data_v [4];
  logic       rx_valid_v [4];
  logic       tx_ready_v [4];
  logic       tx_underrun_v [4];

  int         rx_cnt [4];
  int         un_cnt [4];
  logic [7:0] rx_last [4];
  logic [7:0] rx_log [4][8];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_peripheral_if #(.DATA_WIDTH(8)) bus ();
    spi_peripheral #(
      .DATA_WIDTH(8),
      .CPOL((m / 2) == 1),
      .CPHA((m % 2) == 1),
      .IDLE_WORD(8'hFF)
    ) dut (
      .clock(clock),
      .reset(reset),
      .sclk(sclk_v[m]),
      .pico(pico_v[m]),
      .cs(cs_v[m]),
      .poci(poci_v[m]),
      .poci_oe(poci_oe_v[m]),
      .busy(busy_v[m]),
      .bus(bus)
    );
    assign bus.tx_data       = tx_data_v[m];
    assign bus.tx_valid      = tx_valid_v[m];
    assign rx_data_v[m]      = bus.rx_data;
    assign rx_valid_v[m]     = bus.rx_valid;
    assign tx_ready_v[m]     = bus.tx_ready;
    assign tx_underrun_v[m]  = bus.tx_underrun;
  end

  // Pulse counters and received-word log per mode.
  always @(posedge clock) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_v[m]) begin
        rx_cnt[m] <= rx_cnt[m] + 1;
        rx_last[m] <= rx_data_v[m];
        rx_log[m][rx_cnt[m] % 8] <= rx_data_v[m];
      end
      if (tx_underrun_v[m]) begin
        un_cnt[m] <= un_cnt[m] + 1;
      end
    end
  end

  typedef struct {
    int         mode;
    logic [7:0] tx_word;
    logic [7:0] pico_word;
    logic [7:0] exp_rx;
    logic [7:0] exp_poci;
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand one word to the holding register of mode m.
  task automatic send_tx(input int m, input logic [7:0] w);
    check($sformatf("m%0d ready before load", m), {31'd0, tx_ready_v[m]}, 32'd1);
    tx_data_v[m] = w;
    tx_valid_v[m] = 1'b1;
    tick(1);
    tx_valid_v[m] = 1'b0;
    check($sformatf("m%0d ready after load", m), {31'd0, tx_ready_v[m]}, 32'd0);
  endtask

  // Plain sclk pulse with no data handling.
  task automatic pulse(input int m);
    logic cpol;
    cpol = ((m / 2) == 1);
    sclk_v[m] = ~cpol;
    tick(H);
    sclk_v[m] = cpol;
    tick(H);
  endtask

  // Controller model: one frame of nbits (MSB first), capturing poci.
  task automatic frame(input int m, input int nbits, input logic [15:0] mosi,
                       output logic [15:0] miso);
    logic cpol;
    logic cpha;
    cpol = ((m / 2) == 1);
    cpha = ((m % 2) == 1);
    miso = 16'd0;
    if (!cpha) pico_v[m] = mosi[nbits-1];
    cs_v[m] = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      if (cpha) pico_v[m] = mosi[nbits-1-i];
      else miso = {miso[14:0], poci_v[m]};
      sclk_v[m] = ~cpol;
      tick(H);
      if (cpha) miso = {miso[14:0], poci_v[m]};
      sclk_v[m] = cpol;
      if (!cpha && (i + 1 < nbits)) pico_v[m] = mosi[nbits-2-i];
      tick(H);
    end
    tick(4);
    cs_v[m] = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [15:0] miso;
    int rx0;
    int un0;

    for (int m = 0; m < 4; m++) begin
      sclk_v[m] = ((m / 2) == 1);
      cs_v[m] = 1'b1;
      pico_v[m] = 1'b0;
      tx_data_v[m] = 8'h00;
      tx_valid_v[m] = 1'b0;
    end

    vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{0, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[2] = '{1, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[3] = '{2, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[4] = '{3, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[5] = '{3, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[6] = '{2, 8'h01, 8'h80, 8'h80, 8'h01};

    tick(3);
    reset = 1'b0;
    #0;

    // Reset state, sampled right after reset releases.
    for (int m = 0; m < 4; m++) begin
      check($sformatf("m%0d reset poci", m), {31'd0, poci_v[m]}, 32'd1);
      check($sformatf("m%0d reset poci_oe", m), {31'd0, poci_oe_v[m]}, 32'd0);
    end
    check("reset rx_data", {24'd0, rx_data_v[0]}, 32'h00);
    check("reset rx_valid", {31'd0, rx_valid_v[0]}, 32'd0);
    check("reset tx_ready", {31'd0, tx_ready_v[0]}, 32'd1);
    check("reset tx_underrun", {31'd0, tx_underrun_v[0]}, 32'd0);
    check("reset busy", {31'd0, busy_v[0]}, 32'd0);
    tick(4);

    // Single-word frames from the vector table.
    for (int v = 0; v < 7; v++) begin
      int m;
      m = vecs[v].mode;
      rx0 = rx_cnt[m];
      send_tx(m, vecs[v].tx_word);
      frame(m, 8, {8'h00, vecs[v].pico_word}, miso);
      check($sformatf("v%0d rx_data", v), {24'd0, rx_last[m]}, {24'd0, vecs[v].exp_rx});
      check($sformatf("v%0d rx_valid count", v), rx_cnt[m] - rx0, 32'd1);
      check($sformatf("v%0d poci word", v), {24'd0, miso[7:0]}, {24'd0, vecs[v].exp_poci});
      check($sformatf("v%0d tx_ready", v), {31'd0, tx_ready_v[m]}, 32'd1);
      check($sformatf("v%0d busy", v), {31'd0, busy_v[m]}, 32'd0);
    end

    // Two-word frame with one word preloaded (CPOL=0, CPHA=1).
    rx0 = rx_cnt[1];
    un0 = un_cnt[1];
    send_tx(1, 8'h11);
    frame(1, 16, 16'h0102, miso);
    check("two-word rx count", rx_cnt[1] - rx0, 32'd2);
    check("two-word rx first", {24'd0, rx_log[1][rx0 % 8]}, 32'h01);
    check("two-word rx second", {24'd0, rx_log[1][(rx0 + 1) % 8]}, 32'h02);
    check("two-word poci", {16'd0, miso}, 32'h11FF);
    check("two-word underruns", un_cnt[1] - un0, 32'd1);

    // Abort after 5 bits of 0xF0, then a clean 0x0F frame (mode 0).
    rx0 = rx_cnt[0];
    frame(0, 5, 16'h001E, miso);
    check("abort no rx_valid", rx_cnt[0] - rx0, 32'd0);
    check("abort busy", {31'd0, busy_v[0]}, 32'd0);
    frame(0, 8, 16'h000F, miso);
    check("after abort rx count", rx_cnt[0] - rx0, 32'd1);
    check("after abort rx_data", {24'd0, rx_last[0]}, 32'h0F);
    check("after abort poci", {24'd0, miso[7:0]}, 32'hFF);

    // Reset mid-frame with cs held low: nothing until cs toggles.
    cs_v[0] = 1'b0;
    tick(8);
    pulse(0);
    pulse(0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    rx0 = rx_cnt[0];
    for (int i = 0; i < 8; i++) begin
      pico_v[0] = i[0];
      pulse(0);
      if (i % 3 == 0) check($sformatf("held cs poci_oe p%0d", i), {31'd0, poci_oe_v[0]}, 32'd0);
    end
    tick(8);
    check("held cs no rx_valid", rx_cnt[0] - rx0, 32'd0);
    check("held cs busy", {31'd0, busy_v[0]}, 32'd0);
    cs_v[0] = 1'b1;
    tick(8);
    frame(0, 8, 16'h0055, miso);
    check("rearm rx count", rx_cnt[0] - rx0, 32'd1);
    check("rearm rx_data", {24'd0, rx_last[0]}, 32'h55);

    // Handshake landing on the cs-fall word-start cycle with hold empty.
    check("late ready precheck", {31'd0, tx_ready_v[0]}, 32'd1);
    rx0 = rx_cnt[0];
    cs_v[0] = 1'b0;
    tick(2);
    tx_data_v[0] = 8'h77;
    tx_valid_v[0] = 1'b1;
    tick(1);
    tx_valid_v[0] = 1'b0;
    check("late underrun pulse", {31'd0, tx_underrun_v[0]}, 32'd1);
    check("late word held", {31'd0, tx_ready_v[0]}, 32'd0);
    check("late poci_oe", {31'd0, poci_oe_v[0]}, 32'd1);
    frame(0, 16, 16'h1234, miso);
    check("late poci words", {16'd0, miso}, 32'hFF77);
    check("late rx count", rx_cnt[0] - rx0, 32'd2);
    check("late rx second", {24'd0, rx_last[0]}, 32'h34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target (peripheral) that answers the rvx SPI controller on a board: it receives sclk, pico and cs, and drives poci.
- All SPI inputs are oversampled in the system clock domain. There is no second clock.
- On the parallel side, the block emits received words and accepts words to transmit through a one-entry holding register with a valid/ready handshake.
- Intended use: board-level loopback and protocol bring-up of the SPI demo, and as a bus-model target in simulation.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; MSB first.
- CPOL, 0, sclk idle level.
- CPHA, 0: sample on the leading edge, shift on the trailing edge. 1: shift on the leading edge, sample on the trailing edge.
- IDLE_WORD, {DATA_WIDTH{1'b1}}, word transmitted when no tx word is pending at a word start.

Ports:
- clock  input  1  system clock; must run at least 8x the sclk frequency.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI serial clock, asynchronous to clock.
- pico  input  1  controller-to-peripheral data.
- cs  input  1  chip select, active-low.
- poci  output  1  peripheral-to-controller data.
- poci_oe  output  1  output enable for the poci pad buffer.
- rx_data  output  DATA_WIDTH  last word received.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty.
- tx_underrun  output  1  one-cycle pulse when IDLE_WORD is loaded because the holding register was empty.
- busy  output  1  a frame is in progress (cs is synchronized low and armed).

Behaviour:
- Synchronizers:
  - sclk, pico and cs each pass through a 2-flop synchronizer, followed by a third register for edge detection.
  - Events (sclk edge, cs edge) are therefore acted on 3 clock cycles after the pin changes.
  - pico is sampled from its synchronized value in the same cycle the sample edge is detected.
- Edge definitions:
  - Leading edge: sclk goes from CPOL to !CPOL. Trailing edge: the reverse.
  - CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- Reset:
  - poci=1, poci_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0.
  - Holding register is cleared; bit counter=0; state=IDLE.
  - Synchronizer flops reset to the idle levels (cs=1, sclk=CPOL).
- State machine:
  - IDLE → ACTIVE on a synchronized cs falling edge.
  - ACTIVE → IDLE on a synchronized cs rising edge, or on reset.
  - If cs is already low when reset deasserts, stay in IDLE until cs has gone high and then low again. No partial frame is ever accepted.
- Word load:
  - The tx shift register is loaded at each word start. For CPHA=0: on the cs-fall detect cycle, and on the trailing edge immediately after the DATA_WIDTH-th sample. For CPHA=1: on the first leading edge of each word, in place of a shift.
  - If the holding register is full, its contents load into the shift register, the holding register empties, and tx_ready rises the next cycle.
  - If the holding register is empty, IDLE_WORD loads and tx_underrun pulses for 1 cycle.
- poci and poci_oe:
  - poci = shift register MSB.
  - poci_oe = 1 exactly while state=ACTIVE.
- Receive path:
  - Each sample edge shifts pico into the rx shift register (MSB first) and increments the bit counter.
  - On the DATA_WIDTH-th sample: the full word is copied to rx_data in the same cycle; rx_valid is high the following cycle for exactly 1 cycle; the counter wraps to 0.
  - There is no backpressure. A new word simply overwrites rx_data.
- tx handshake:
  - Transfer happens when tx_valid && tx_ready.
  - tx_ready drops the cycle after the transfer.
  - tx_data is accepted at any time, whether IDLE or ACTIVE.
  - If a word-start load and a handshake occur in the same cycle with the holding register empty, the new word is not used for the current word: IDLE_WORD loads and the new word stays held.
- Abort:
  - A cs rising edge mid-word discards the partial rx word: no rx_valid, counter cleared.
  - The tx word that was in the shift register is lost. The holding register is untouched.
- Glitches:
  - sclk edges seen while IDLE are ignored.
  - A cs pulse shorter than 3 clock cycles may be missed; this is permitted.

Test Plan:
- CPOL=0, CPHA=0. Preload tx 0xA5. Controller sends 0x3C in one frame at clock/8 → rx_data=0x3C with a single rx_valid pulse; controller receives 0xA5; tx_ready returns to 1 after the cs-fall load.
- Two-word frame with only 0x11 preloaded. Controller sends 0x01, 0x02 → rx_valid pulses twice with 0x01 then 0x02; controller receives 0x11 then 0xFF; exactly one tx_underrun pulse, at the second word start.
- All four CPOL/CPHA combinations, loopback 0x96 → received 0x96 and transmitted 0x96 bit-exact in each mode.
- cs deasserted after 5 bits of 0xF0, then a new frame sending 0x0F → no rx_valid for the aborted word; next rx_data=0x0F; counter restarted.
- reset asserted mid-frame while cs is held low, then 8 sclk pulses, then cs high→low and byte 0x55 → the first 8 pulses produce no rx_valid and poci_oe=0; the second frame yields rx_data=0x55.
- tx_valid held high with 0x77 during IDLE, plus a simultaneous handshake on a word-start cycle while the holding register is empty → the current word is IDLE_WORD with tx_underrun; the next word transmits 0x77.
